// File: rtl/wb_slave_regfile_pkg.sv
// Shared types for the Wishbone register-file slave.
// The FSM state encoding lives here so the top and any checkers agree on it.
package wb_slave_regfile_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WAIT,
        STATE_RESPOND
    } state_t;

    localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/wb_slave_regfile_bank.sv
// Register storage: NUM_REGS words, byte-enable write port, asynchronous read port.
// Addresses at or above NUM_REGS match no word, so they neither write nor read.
module wb_slave_regfile_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_sel,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < SEL_WIDTH; b++) begin
                        if (wr_sel[b]) begin
                            regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic-cycle slave over a register bank, with WAIT_CYCLES wait states
// and a single-cycle ACK (mapped) or ERR (unmapped) termination.
module wb_slave_regfile
    import wb_slave_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    state_t                    state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_adr;
    logic [SEL_WIDTH-1:0]      req_sel;
    logic [DATA_WIDTH-1:0]     req_dat;

    logic                      take_req;
    logic                      enter_resp;
    logic                      eff_we;
    logic                      eff_mapped;
    logic [ADDR_WIDTH-1:0]     eff_adr;
    logic [SEL_WIDTH-1:0]      eff_sel;
    logic [DATA_WIDTH-1:0]     eff_dat;
    logic [DATA_WIDTH-1:0]     rd_data;

    // With no wait states the response is produced on the acceptance edge itself,
    // so the live bus values stand in for the not-yet-latched request.
    always_comb begin
        take_req   = (state == STATE_IDLE) && cyc_i && stb_i;
        eff_we     = take_req ? we_i  : req_we;
        eff_adr    = take_req ? adr_i : req_adr;
        eff_sel    = take_req ? sel_i : req_sel;
        eff_dat    = take_req ? dat_i : req_dat;
        enter_resp = (take_req && NO_WAIT)
                   || ((state == STATE_WAIT) && cyc_i && (wait_cnt == '0));
        eff_mapped = ({1'b0, eff_adr} < (ADDR_WIDTH + 1)'(NUM_REGS));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= STATE_IDLE;
            wait_cnt <= '0;
            req_we   <= 1'b0;
            req_adr  <= '0;
            req_sel  <= '0;
            req_dat  <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
        end else begin
            ack_o <= enter_resp && eff_mapped;
            err_o <= enter_resp && !eff_mapped;
            dat_o <= (enter_resp && eff_mapped && !eff_we) ? rd_data : '0;
            case (state)
                STATE_IDLE: begin
                    if (take_req) begin
                        req_we  <= we_i;
                        req_adr <= adr_i;
                        req_sel <= sel_i;
                        req_dat <= dat_i;
                        if (NO_WAIT) begin
                            state <= STATE_RESPOND;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= STATE_WAIT;
                        end
                    end
                end
                STATE_WAIT: begin
                    // Only cyc_i aborts; a dropped stb_i mid-wait is ignored.
                    if (!cyc_i) begin
                        state <= STATE_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= STATE_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                STATE_RESPOND: state <= STATE_IDLE;
                default:       state <= STATE_IDLE;
            endcase
        end
    end

    wb_slave_regfile_bank #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_bank (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_en  (enter_resp && eff_we && eff_mapped),
        .wr_addr(eff_adr),
        .wr_sel (eff_sel),
        .wr_data(eff_dat),
        .rd_addr(eff_adr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: one instance with no wait states, one with three,
// checked every cycle against a transfer-level model of the register file.
module tb_wb_slave_regfile;

    localparam int NREGS = 12;

    logic        clk;
    logic        rst   [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  adr   [2];
    logic [3:0]  sel   [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic        ack   [2];
    logic        err   [2];

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Model: register contents per instance plus the expected termination,
    // keyed by (edge index * 2 + instance); any cycle without an entry must be quiet.
    logic [31:0] mem [2][16];
    int          exp_kind [int];
    logic [31:0] exp_dat  [int];

    wb_slave_regfile #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(NREGS), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(dat_w[0]), .dat_o(dat_r[0]),
        .ack_o(ack[0]), .err_o(err[0])
    );

    wb_slave_regfile #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(NREGS), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(dat_w[1]), .dat_o(dat_r[1]),
        .ack_o(ack[1]), .err_o(err[1])
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    // Per-cycle compare of {ack, err, dat} against the model schedule
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            for (int k = 0; k < 2; k++) begin
                int          key;
                logic [33:0] exp_v;
                logic [33:0] act_v;
                key   = edge_n * 2 + k;
                exp_v = '0;
                if (exp_kind.exists(key)) begin
                    exp_v = {exp_kind[key] == 1, exp_kind[key] == 2, exp_dat[key]};
                end
                act_v = {ack[k], err[k], dat_r[k]};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_check dut%0d edge %0d: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                             k, edge_n, act_v[33], act_v[32], act_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Transfer-level model: decides the termination and updates the registers.
    task automatic model_xfer(input int k, input bit w, input logic [3:0] a,
                              input logic [3:0] s, input logic [31:0] d, input int key);
        if (a < NREGS) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) mem[k][a][8*b +: 8] = d[8*b +: 8];
                end
                exp_dat[key] = '0;
            end else begin
                exp_dat[key] = mem[k][a];
            end
            exp_kind[key] = 1;
        end else begin
            exp_kind[key] = 2;
            exp_dat[key]  = '0;
        end
    endtask

    task automatic clear_bus(input int k);
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        adr[k] = '0; sel[k] = '0; dat_w[k] = '0;
    endtask

    // Driver: called at a negedge with the slave idle. abort_k >= 0 drops cyc_i
    // so that the slave sees it abort_k+1 edges after acceptance.
    task automatic xfer(input int k, input bit w, input logic [3:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_k,
                        output logic [31:0] rd, output logic got_ack, output logic got_err);
        int e0;
        int wc;
        wc = wait_of(k);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
        e0 = edge_n + 1;
        if (abort_k < 0) model_xfer(k, w, a, s, d, (e0 + wc) * 2 + k);
        rd = '0; got_ack = 1'b0; got_err = 1'b0;
        for (int n = 0; n <= wc; n++) begin
            @(negedge clk);
            if (abort_k >= 0 && edge_n == e0 + abort_k) begin
                clear_bus(k);
                @(negedge clk);
                return;
            end
            if (edge_n == e0 + wc) begin
                rd = dat_r[k]; got_ack = ack[k]; got_err = err[k];
                clear_bus(k);
                @(negedge clk);
                return;
            end
            // Bus noise during wait states must be ignored by the slave.
            stb[k]   = 1'($urandom_range(0, 1));
            we[k]    = 1'($urandom_range(0, 1));
            adr[k]   = 4'($urandom_range(0, 15));
            sel[k]   = 4'($urandom_range(0, 15));
            dat_w[k] = $urandom;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;
        logic        er;

        for (int k = 0; k < 2; k++) begin
            clear_bus(k);
            rst[k] = 1'b1;
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        // No wait states: full write then read back
        xfer(0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, -1, rd, ak, er);
        check("w0_write_ack", {31'd0, ak}, 32'd1);
        xfer(0, 1'b0, 4'd3, 4'hF, 32'h0, -1, rd, ak, er);
        check("w0_read_data", rd, 32'hDEADBEEF);

        // Byte lanes
        xfer(0, 1'b1, 4'd5, 4'hF, 32'h11223344, -1, rd, ak, er);
        xfer(0, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD, -1, rd, ak, er);
        xfer(0, 1'b0, 4'd5, 4'h0, 32'h0, -1, rd, ak, er);
        check("byte_lane_read", rd, 32'h11BB33DD);

        // Three wait states, read after reset
        xfer(1, 1'b0, 4'd0, 4'hF, 32'h0, -1, rd, ak, er);
        check("w3_read_reset_val", rd, 32'h0);
        check("w3_read_ack", {30'd0, ak, er}, 32'd2);

        // Unmapped write then read
        xfer(0, 1'b1, 4'd14, 4'hF, 32'hCAFEF00D, -1, rd, ak, er);
        check("unmapped_write_term", {30'd0, ak, er}, 32'd1);
        xfer(0, 1'b0, 4'd14, 4'hF, 32'h0, -1, rd, ak, er);
        check("unmapped_read_term", {30'd0, ak, er}, 32'd1);
        check("unmapped_read_data", rd, 32'h0);
        for (int i = 0; i < NREGS; i++) xfer(0, 1'b0, 4'(i), 4'hF, 32'h0, -1, rd, ak, er);

        // Abort during wait: prior value must survive
        xfer(1, 1'b1, 4'd2, 4'hF, 32'h12345678, -1, rd, ak, er);
        xfer(1, 1'b1, 4'd2, 4'hF, 32'h00000005, 1, rd, ak, er);
        xfer(1, 1'b0, 4'd2, 4'hF, 32'h0, -1, rd, ak, er);
        check("abort_keeps_value", rd, 32'h12345678);

        // Randomized traffic, including aborts on the wait-state instance
        for (int i = 0; i < 80; i++) begin
            int k;
            int ab;
            k  = $urandom_range(0, 1);
            ab = -1;
            if (k == 1 && $urandom_range(0, 5) == 0) ab = $urandom_range(0, 2);
            xfer(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom, ab, rd, ak, er);
        end
        for (int i = 0; i < NREGS; i++) xfer(1, 1'b0, 4'(i), 4'hF, 32'h0, -1, rd, ak, er);

        // Reset in the middle of a waited write
        xfer(1, 1'b1, 4'd7, 4'hF, 32'hFFFFFFFF, -1, rd, ak, er);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd7; sel[1] = 4'hF; dat_w[1] = 32'h0BADF00D;
        @(negedge clk);
        rst[1] = 1'b1;
        clear_bus(1);
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 16; i++) mem[1][i] = '0;
        for (int i = 0; i < NREGS; i++) begin
            xfer(1, 1'b0, 4'(i), 4'hF, 32'h0, -1, rd, ak, er);
            check($sformatf("post_reset_reg%0d", i), {ak, rd[30:0]}, 32'h80000000);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_regfile.md
# wb_slave_regfile

Wishbone B4 classic-cycle slave exposing a bank of read/write registers with a configurable number of wait states. It is the responder for the codebase's Wishbone masters: it samples CYC/STB, inserts wait states, then terminates each transfer with a single-cycle ACK, or ERR for unmapped addresses. It is the default endpoint for bus-level testbenches and for simple control/status blocks.

## Interface

- `ADDR_WIDTH`, 4: word-address width; addresses are word indices, with no byte-lane bits.
- `DATA_WIDTH`, 32: data bus width; must be a multiple of 8.
- `NUM_REGS`, 12: number of implemented registers, 1..2**ADDR_WIDTH; address ≥ NUM_REGS is unmapped.
- `WAIT_CYCLES`, 0: wait states inserted before termination, 0..15.
- `clk_i`  in  1  sole clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cyc_i`  in  1  bus cycle in progress.
- `stb_i`  in  1  strobe; a transfer is requested when cyc_i & stb_i.
- `we_i`  in  1  1 = write, 0 = read.
- `adr_i`  in  ADDR_WIDTH  word address.
- `sel_i`  in  DATA_WIDTH/8  byte-lane select; bit n covers dat bits 8n+7..8n.
- `dat_i`  in  DATA_WIDTH  write data.
- `dat_o`  out  DATA_WIDTH  read data, valid while ack_o=1 on a read.
- `ack_o`  out  1  normal termination, one-cycle pulse.
- `err_o`  out  1  error termination, one-cycle pulse.

## Operation

- States (`state_t`): `STATE_IDLE`, `STATE_WAIT`, `STATE_RESPOND`.
- `STATE_IDLE`: when cyc_i & stb_i, latch adr_i/we_i/sel_i/dat_i.
  - If WAIT_CYCLES=0, go to RESPOND.
  - Otherwise load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- `STATE_WAIT`: if !cyc_i, abort to IDLE with no write and no termination.
  - Else if counter=0, go to RESPOND.
  - Else decrement the counter.
- Entering `STATE_RESPOND` (registered, same edge):
  - Mapped write: each register byte with sel=1 takes the latched dat_i byte. Other bytes are unchanged. dat_o=0. ack_o=1.
  - Mapped read: dat_o = register contents, all lanes regardless of sel. ack_o=1.
  - Unmapped access: err_o=1, dat_o=0, no register changes.
- `STATE_RESPOND` lasts exactly one cycle, then returns to IDLE. ack_o, err_o and dat_o clear on that edge.
- Exactly one of ack_o/err_o is asserted per accepted transfer; never both. They are never asserted outside RESPOND.
- Address, data, sel and we values used are those latched at acceptance. Input changes during WAIT are ignored.
- sel_i=0 on a write still ACKs, with no register change.
- Reset, including mid-transfer: state=IDLE; ack_o=0, err_o=0, dat_o=0; all registers 0; counter 0. Any pending transfer is dropped without termination.

## Timing

- Request sampled at edge E0 while in IDLE. ack_o/err_o is high during the cycle after edge E0+WAIT_CYCLES, and the master samples it at edge E0+WAIT_CYCLES+1.
- A write is visible to a read accepted at any later edge.
- After RESPOND there is one mandatory IDLE cycle. Back-to-back transfers therefore complete every WAIT_CYCLES+2 cycles.
- A master that drops stb_i on the ACK edge produces no duplicate transfer. A request still held in the IDLE cycle after RESPOND is a new transfer.
- stb_i falling during WAIT while cyc_i stays high does not abort the transfer; only cyc_i aborts.

## Structure

- Package `wb_slave_regfile_pkg` holds the `state_t` enum.
- Sub-module `wb_slave_regfile_bank` holds the register storage:
  - NUM_REGS×DATA_WIDTH array with byte-enable write port and asynchronous read port.
  - Reset-to-zero on rst_i.
- The top module holds the FSM, the wait counter, the request latch and the output registers.

## Test plan

- WAIT_CYCLES=0: write 0xDEADBEEF to adr 3 with sel=4'hF, then read adr 3. Each transfer gets ack_o at exactly E0+1, and the read gives dat_o=0xDEADBEEF.
- Byte lanes: reg 5 = 0x11223344; write 0xAABBCCDD with sel=4'b0101, then read. dat_o=0x11BB33DD.
- WAIT_CYCLES=3: read adr 0. ack_o is low for 3 cycles after E0, high in exactly one cycle, then low. Read returns 0 after reset.
- Unmapped: NUM_REGS=12, write then read adr 14. err_o pulses once and ack_o stays 0; the read gives dat_o=0 and no register changes (reads of adr 0..11 unchanged).
- Abort: WAIT_CYCLES=4, write 0x5 to adr 2, drop cyc_i after 2 cycles. No ack/err; a subsequent read of adr 2 returns its prior value.
- Reset mid-op: assert rst_i during WAIT of a write. The next cycle has outputs 0, the state accepts a new request, and all registers read 0.
